// File: rtl/bus_demux1x4.sv
// ---------------------------------------------------------------------------
// bus_demux1x4
//
// Routes single master transactions to one of four slaves chosen by address
// bits [31:30]. A request is latched in IDLE, the slave is strobed in BUSY
// until it acknowledges or a timeout expires, and a one-cycle m_ack (with
// m_err qualifying a timeout) is returned in RESP.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous active-low reset
//   m_req, m_we              master request strobe and write enable
//   m_addr, m_wdata          master address and write data
//   m_rdata                  registered read data back to the master
//   m_ack, m_err             one-cycle completion pulse and its error flag
//   s_req                    one-hot slave request
//   s_we, s_addr, s_wdata    latched copies of the master request
//   s_rdata0..s_rdata3       per-slave read data
//   s_ack                    per-slave acknowledge
//   err_cnt                  saturating count of timeouts
// ---------------------------------------------------------------------------
module bus_demux1x4 #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_req,
    input  logic             m_we,
    input  logic [31:0]      m_addr,
    input  logic [WIDTH-1:0] m_wdata,
    output logic [WIDTH-1:0] m_rdata,
    output logic             m_ack,
    output logic             m_err,
    output logic [3:0]       s_req,
    output logic             s_we,
    output logic [31:0]      s_addr,
    output logic [WIDTH-1:0] s_wdata,
    input  logic [WIDTH-1:0] s_rdata0,
    input  logic [WIDTH-1:0] s_rdata1,
    input  logic [WIDTH-1:0] s_rdata2,
    input  logic [WIDTH-1:0] s_rdata3,
    input  logic [3:0]       s_ack,
    output logic [7:0]       err_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // The counter only has to hold 0..TIMEOUT-1; the TIMEOUT-th miss ends BUSY.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       s_req_q, s_req_d;
    logic             s_we_q, s_we_d;
    logic [31:0]      s_addr_q, s_addr_d;
    logic [WIDTH-1:0] s_wdata_q, s_wdata_d;
    logic [WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic             m_ack_q, m_ack_d;
    logic             m_err_q, m_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [1:0]       sel;
    logic [WIDTH-1:0] sel_rdata;
    logic             sel_ack;

    // The latched address doubles as the slave select.
    assign sel     = s_addr_q[31:30];
    assign sel_ack = s_ack[sel];

    always_comb begin
        sel_rdata = s_rdata0;
        unique case (sel)
            2'd0: sel_rdata = s_rdata0;
            2'd1: sel_rdata = s_rdata1;
            2'd2: sel_rdata = s_rdata2;
            2'd3: sel_rdata = s_rdata3;
            default: sel_rdata = s_rdata0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = 1'b0;
        m_err_d   = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            StIdle: begin
                if (m_req) begin
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    cnt_d     = '0;
                    s_req_d   = 4'b0001 << m_addr[31:30];
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (sel_ack) begin
                    // Ack takes priority over a timeout in the same cycle.
                    state_d = StResp;
                    s_req_d = 4'b0000;
                    m_ack_d = 1'b1;
                    if (!s_we_q) begin
                        m_rdata_d = sel_rdata;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d   = StResp;
                    s_req_d   = 4'b0000;
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = '0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                s_req_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            s_req_q   <= 4'b0000;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign s_req   = s_req_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign m_rdata = m_rdata_q;
    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign err_cnt = err_cnt_q;

endmodule
